// File: rtl/h2f_mailbox_dispatcher.sv
// FPGA-side consumer of the HPS lightweight-bridge mailbox RAM.
// Polls the doorbell word, fetches the two argument words, hands the command
// to the CNN engine over a valid/ready handshake, waits for the completion
// pulse (or a timeout), writes the status word and finally clears GO.
module h2f_mailbox_dispatcher #(
    parameter int POLL_INTERVAL  = 16,
    parameter int READ_LATENCY   = 1,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int CNT_W          = 21
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [1:0]  ram_address,
    output logic        ram_chipselect,
    output logic        ram_write,
    output logic [3:0]  ram_byteenable,
    output logic [31:0] ram_writedata,
    input  logic [31:0] ram_readdata,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_opcode,
    output logic [7:0]  cmd_tag,
    output logic [31:0] cmd_arg0,
    output logic [31:0] cmd_arg1,
    input  logic        rsp_valid,
    input  logic [15:0] rsp_result,
    output logic        busy,
    output logic        timeout_err
);

    localparam int RD_W = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        RD2,
        ISSUE,
        WAIT_RSP,
        WR3,
        CLR0
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              rst_n;
    logic [1:0]        rst_sync;
    logic [CNT_W-1:0]  poll_cnt;
    logic [CNT_W-1:0]  tmo_cnt;
    logic [RD_W-1:0]   rd_cnt;
    logic [15:0]       result;
    logic              err;

    logic              poll_done;
    logic              tmo_expire;
    logic              rd_state;
    logic              rd_strobe;
    logic              rd_done;
    logic              rsp_take;
    logic              tmo_fire;
    logic [31:0]       status_word;

    // Reset asserts asynchronously but is released only on a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    assign poll_done   = (POLL_INTERVAL == 0) || (poll_cnt == CNT_W'(POLL_INTERVAL - 1));
    assign tmo_expire  = (TIMEOUT_CYCLES != 0) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign rd_state    = (state == RD0) || (state == RD1) || (state == RD2);
    assign rd_strobe   = (rd_cnt == '0);
    assign rd_done     = (rd_cnt == RD_W'(READ_LATENCY));
    assign status_word = {1'b1, err, 6'b000000, cmd_tag, result};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus the RAM strobes and the command valid.
    always_comb begin
        next_state     = state;
        ram_address    = 2'd0;
        ram_chipselect = 1'b0;
        ram_write      = 1'b0;
        ram_byteenable = 4'b0000;
        ram_writedata  = 32'h0000_0000;
        cmd_valid      = 1'b0;
        rsp_take       = 1'b0;
        tmo_fire       = 1'b0;
        case (state)
            IDLE: begin
                if (poll_done) begin
                    next_state = RD0;
                end
            end
            RD0: begin
                ram_address    = 2'd0;
                ram_chipselect = rd_strobe;
                ram_byteenable = rd_strobe ? 4'b1111 : 4'b0000;
                if (rd_done) begin
                    if (ram_readdata[31]) begin
                        next_state = RD1;
                    end else if (POLL_INTERVAL == 0) begin
                        next_state = RD0;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            RD1: begin
                ram_address    = 2'd1;
                ram_chipselect = rd_strobe;
                ram_byteenable = rd_strobe ? 4'b1111 : 4'b0000;
                if (rd_done) begin
                    next_state = RD2;
                end
            end
            RD2: begin
                ram_address    = 2'd2;
                ram_chipselect = rd_strobe;
                ram_byteenable = rd_strobe ? 4'b1111 : 4'b0000;
                if (rd_done) begin
                    next_state = (cmd_opcode == 8'h00) ? WR3 : ISSUE;
                end
            end
            ISSUE: begin
                cmd_valid = 1'b1;
                if (tmo_expire) begin
                    tmo_fire   = 1'b1;
                    next_state = WR3;
                end else if (cmd_ready) begin
                    next_state = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (rsp_valid) begin
                    rsp_take   = 1'b1;
                    next_state = WR3;
                end else if (tmo_expire) begin
                    tmo_fire   = 1'b1;
                    next_state = WR3;
                end
            end
            WR3: begin
                ram_address    = 2'd3;
                ram_chipselect = 1'b1;
                ram_write      = 1'b1;
                ram_byteenable = 4'b1111;
                ram_writedata  = status_word;
                next_state     = CLR0;
            end
            CLR0: begin
                ram_address    = 2'd0;
                ram_chipselect = 1'b1;
                ram_write      = 1'b1;
                ram_byteenable = 4'b1000;
                ram_writedata  = 32'h0000_0000;
                next_state     = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Counters, latched command fields, result capture and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poll_cnt    <= '0;
            tmo_cnt     <= '0;
            rd_cnt      <= '0;
            cmd_opcode  <= 8'h00;
            cmd_tag     <= 8'h00;
            cmd_arg0    <= 32'h0000_0000;
            cmd_arg1    <= 32'h0000_0000;
            result      <= 16'h0000;
            err         <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            poll_cnt <= (state == IDLE) ? poll_cnt + 1'b1 : '0;
            tmo_cnt  <= ((state == ISSUE) || (state == WAIT_RSP)) ? tmo_cnt + 1'b1 : '0;
            if (rd_state) begin
                rd_cnt <= rd_done ? '0 : rd_cnt + 1'b1;
            end else begin
                rd_cnt <= '0;
            end
            if ((state == RD0) && rd_done && ram_readdata[31]) begin
                cmd_opcode  <= ram_readdata[7:0];
                cmd_tag     <= ram_readdata[15:8];
                busy        <= 1'b1;
                timeout_err <= 1'b0;
                result      <= 16'h0000;
                err         <= 1'b0;
            end
            if ((state == RD1) && rd_done) begin
                cmd_arg0 <= ram_readdata;
            end
            if ((state == RD2) && rd_done) begin
                cmd_arg1 <= ram_readdata;
            end
            if (rsp_take) begin
                result <= rsp_result;
            end
            if (tmo_fire) begin
                result      <= 16'h0000;
                err         <= 1'b1;
                timeout_err <= 1'b1;
            end
            if (state == CLR0) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: doc/h2f_mailbox_dispatcher.md
Name: h2f_mailbox_dispatcher

Overview:
- FPGA-side consumer of the 4-word x 32-bit HPS lightweight-bridge mailbox RAM.
- Polls the doorbell word and, once HPS sets GO, reads the two argument words.
- Hands the command to the CNN engine through a valid/ready handshake, waits for the engine response or a timeout, writes the status word back, then clears GO.
- Sits between the mailbox RAM port and the posture-recognition CNN control path.

Parameters:
- POLL_INTERVAL, 16: idle cycles between successive doorbell reads; 0 means back-to-back polling.
- READ_LATENCY, 1: cycles from read address presentation to valid readdata (address registered, output unregistered).
- TIMEOUT_CYCLES, 1048576: maximum cycles spent in ISSUE plus WAIT_RSP; 0 disables the timeout.
- CNT_W, 21: width of the poll and timeout counters; must satisfy 2^CNT_W > max(POLL_INTERVAL, TIMEOUT_CYCLES).

Ports:
- clk  in  1  system clock; RAM clock shared.
- reset_n  in  1  asynchronous active-low reset.
- ram_address  out  2  mailbox word index.
- ram_chipselect  out  1  RAM access strobe.
- ram_write  out  1  write enable, qualified by chipselect.
- ram_byteenable  out  4  byte lanes for writes.
- ram_writedata  out  32  write data.
- ram_readdata  in  32  read data, READ_LATENCY after address.
- cmd_valid  out  1  command offered to engine.
- cmd_ready  in  1  engine accepts command.
- cmd_opcode  out  8  word0[7:0].
- cmd_tag  out  8  word0[15:8].
- cmd_arg0  out  32  word1.
- cmd_arg1  out  32  word2.
- rsp_valid  in  1  one-cycle engine completion pulse.
- rsp_result  in  16  engine result, valid with rsp_valid.
- busy  out  1  high from GO detection until GO is cleared.
- timeout_err  out  1  sticky; cleared on the next GO detection.

Behaviour:
- Word map:
  - word0: GO = bit31; bits 30:16 reserved; tag = [15:8]; opcode = [7:0].
  - word1: arg0.
  - word2: arg1.
  - word3: status = {DONE, ERR, 6'b0, tag[7:0], result[15:0]}.
- Reset (async assert, sync release): FSM to IDLE; every output is 0 (ram_byteenable = 4'b0000); counters cleared; RAM contents untouched. If GO is still set after reset, the command re-executes.
- Reads: chipselect=1, write=0, byteenable=4'b1111 for one cycle; readdata is sampled exactly READ_LATENCY cycles later. Only one outstanding read.
- Writes: chipselect=1, write=1 for exactly one cycle.
- FSM:
  - IDLE: count POLL_INTERVAL cycles, then go to RD0.
  - RD0: read word0 and wait for the latency.
    - GO=0: back to IDLE with the counter reset.
    - GO=1: latch opcode and tag; set busy; clear timeout_err; go to RD1.
  - RD1: read word1 and latch cmd_arg0. RD2: read word2 and latch cmd_arg1.
    - opcode==0 (NOP): skip the engine; go to WR3 with result=0, ERR=0.
    - Otherwise go to ISSUE.
  - ISSUE: cmd_valid=1 with stable payload until cmd_valid&cmd_ready. Then drop cmd_valid the next cycle and go to WAIT_RSP.
  - WAIT_RSP: on rsp_valid, latch rsp_result and go to WR3. A rsp_valid in the same cycle as the handshake is ignored; the engine responds at least one cycle after acceptance.
  - Timeout counter: starts at ISSUE entry. When it reaches TIMEOUT_CYCLES in ISSUE or WAIT_RSP, drop cmd_valid, set timeout_err, set result=0 and ERR=1, and go to WR3. A rsp_valid on the same cycle as expiry wins: normal completion.
  - WR3: write word3 = {1,ERR,6'b0,tag,result}, byteenable 4'b1111.
  - CLR0: write word0 with writedata=0, byteenable=4'b1000. This clears GO and bits 30:24; tag and opcode are preserved. Drop busy; go to IDLE.
- Ordering: the status write always precedes the GO clear, so HPS sees DONE before GO falls.
- No RAM access occurs while in ISSUE or WAIT_RSP.
- rsp_valid outside WAIT_RSP is ignored.

Test Plan:
- Preload word0=0: the only RAM accesses are word0 reads, spaced POLL_INTERVAL+1+READ_LATENCY cycles apart; cmd_valid stays 0.
- Preload word0=0x8000_2A05, word1=0x1234_5678, word2=0xCAFE_0001; engine ready at once, rsp_valid 10 cycles later with result 0x00BEEF:
  - cmd presents opcode 0x05, tag 0x2A and both args.
  - word3=0x802A_BEEF is written.
  - word0 then becomes 0x0000_2A05; busy rises then falls.
- cmd_ready held low for 7 cycles: cmd_valid and payload stay stable for all 7 cycles; exactly one handshake occurs.
- TIMEOUT_CYCLES=50, engine never responds: cmd_valid falls at the timeout; word3=0xC02A_0000; timeout_err=1; GO is cleared. The next GO clears timeout_err.
- Doorbell 0x8000_0700 (NOP): no cmd_valid; word3=0x8007_0000; GO is cleared.
- reset_n pulsed low during WAIT_RSP: all outputs go to 0 immediately. After release the same command re-executes (GO still set) and completes normally.
